// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: turns CPU write-back strobes into timestamped trace
// records held in a first-word-fall-through FIFO drained over valid/ready.
module commit_trace_buffer #(
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16,
   parameter int DROP_W = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [31:0]       pc_i,
   input  logic              rf_we_i,
   input  logic [4:0]        rf_addr_i,
   input  logic [31:0]       rf_data_i,
   input  logic              dm_we_i,
   input  logic [31:0]       dm_addr_i,
   input  logic [31:0]       dm_data_i,
   output logic              trace_valid_o,
   input  logic              trace_ready_i,
   output logic [1:0]        trace_kind_o,
   output logic [31:0]       trace_pc_o,
   output logic [31:0]       trace_addr_o,
   output logic [31:0]       trace_data_o,
   output logic [TS_W-1:0]   trace_ts_o,
   output logic [CW-1:0]     count_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [DROP_W-1:0] drop_cnt_o
);

   typedef struct packed {
      logic [1:0]      kind;
      logic [31:0]     pc;
      logic [31:0]     addr;
      logic [31:0]     data;
      logic [TS_W-1:0] ts;
   } rec_t;

   localparam logic [1:0] KIND_RF = 2'b01;
   localparam logic [1:0] KIND_DM = 2'b10;

   rec_t              mem [DEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic [CW-1:0]     count;
   logic [TS_W-1:0]   ts;
   logic [DROP_W-1:0] drop_cnt;

   logic        rf_cand, dm_cand, pop, push_rf, push_dm;
   logic [CW-1:0] space;
   logic [1:0]  npush, ndrop;
   rec_t        rf_rec, dm_rec, head;

   assign empty_o = (count == '0);
   assign full_o  = (count == CW'(DEPTH));
   assign pop     = !empty_o && trace_ready_i;

   // Space counts the slot freed by a same-cycle pop; RF is served first.
   always_comb begin
      rf_cand = en_i && rf_we_i && (rf_addr_i != 5'd0);
      dm_cand = en_i && dm_we_i;
      space   = CW'(DEPTH) - count + CW'(pop);
      push_rf = rf_cand && (space != '0);
      push_dm = dm_cand && (push_rf ? (space >= CW'(2)) : (space != '0));
      npush   = 2'(push_rf) + 2'(push_dm);
      ndrop   = 2'(rf_cand && !push_rf) + 2'(dm_cand && !push_dm);
      rf_rec  = '{kind: KIND_RF, pc: pc_i, addr: {27'd0, rf_addr_i}, data: rf_data_i, ts: ts};
      dm_rec  = '{kind: KIND_DM, pc: pc_i, addr: dm_addr_i, data: dm_data_i, ts: ts};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         ts       <= '0;
         drop_cnt <= '0;
      end else begin
         wptr  <= wptr + AW'(npush);
         rptr  <= rptr + AW'(pop);
         count <= count + CW'(npush) - CW'(pop);
         ts    <= ts + TS_W'(en_i);
         if (drop_cnt > ({DROP_W{1'b1}} - DROP_W'(ndrop)))
            drop_cnt <= '1;
         else
            drop_cnt <= drop_cnt + DROP_W'(ndrop);
      end
   end

   // Storage carries no reset; occupancy alone decides what is live.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (push_rf) mem[wptr] <= rf_rec;
         if (push_dm) mem[push_rf ? wptr + AW'(1) : wptr] <= dm_rec;
      end
   end

   assign head          = empty_o ? '0 : mem[rptr];
   assign trace_valid_o = !empty_o;
   assign trace_kind_o  = head.kind;
   assign trace_pc_o    = head.pc;
   assign trace_addr_o  = head.addr;
   assign trace_data_o  = head.data;
   assign trace_ts_o    = head.ts;
   assign count_o       = count;
   assign drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized + directed bench for commit_trace_buffer; a queue-based model
// predicts records and a negedge monitor checks each popped head.
module tb_commit_trace_buffer;
   localparam int DEPTH = 16;
   localparam int TS_W  = 16;
   localparam int DROP_W = 16;

   logic clk = 0, rst_i = 0, en_i = 0, rf_we_i = 0, dm_we_i = 0, trace_ready_i = 0;
   logic [31:0] pc_i = 0, rf_data_i = 0, dm_addr_i = 0, dm_data_i = 0;
   logic [4:0] rf_addr_i = 0;
   logic trace_valid_o, full_o, empty_o;
   logic [1:0] trace_kind_o;
   logic [31:0] trace_pc_o, trace_addr_o, trace_data_o;
   logic [TS_W-1:0] trace_ts_o;
   logic [4:0] count_o;
   logic [DROP_W-1:0] drop_cnt_o;

   commit_trace_buffer #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pc_i(pc_i),
      .rf_we_i(rf_we_i), .rf_addr_i(rf_addr_i), .rf_data_i(rf_data_i),
      .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_data_i(dm_data_i),
      .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
      .trace_kind_o(trace_kind_o), .trace_pc_o(trace_pc_o), .trace_addr_o(trace_addr_o),
      .trace_data_o(trace_data_o), .trace_ts_o(trace_ts_o), .count_o(count_o),
      .full_o(full_o), .empty_o(empty_o), .drop_cnt_o(drop_cnt_o));

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] kind; logic [31:0] pc, addr, data; logic [TS_W-1:0] ts;
   } rec_t;

   rec_t exp_q[$];
   int   mcount = 0;
   int   mdrop  = 0;
   int   mts    = 0;
   int   nvec = 0, nerr = 0;

   function automatic void chk(input string name, input longint act, input longint req);
      nvec++;
      if (act != req) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endfunction

   // Monitor: every accepted head must match the oldest predicted record.
   always @(negedge clk) begin
      if (!rst_i && trace_valid_o && trace_ready_i) begin
         if (exp_q.size() == 0) begin
            chk("pop_underflow", 1, 0);
         end else begin
            rec_t e;
            e = exp_q.pop_front();
            chk("rec_kind", trace_kind_o, e.kind);
            chk("rec_pc",   trace_pc_o,   e.pc);
            chk("rec_addr", trace_addr_o, e.addr);
            chk("rec_data", trace_data_o, e.data);
            chk("rec_ts",   trace_ts_o,   e.ts);
         end
      end
   end

   // One cycle: check visible state, drive inputs, advance the model, clock.
   task automatic step(input bit en, input bit rfwe, input logic [4:0] ra, input logic [31:0] rd,
                       input bit dmwe, input logic [31:0] da, input logic [31:0] dd,
                       input logic [31:0] pc, input bit rdy, input bit rst);
      int space;
      chk("count", count_o, mcount);
      chk("empty", empty_o, mcount == 0);
      chk("full",  full_o,  mcount == DEPTH);
      chk("valid", trace_valid_o, mcount != 0);
      chk("drop",  drop_cnt_o, mdrop);
      rst_i = rst; en_i = en; rf_we_i = rfwe; rf_addr_i = ra; rf_data_i = rd;
      dm_we_i = dmwe; dm_addr_i = da; dm_data_i = dd; pc_i = pc; trace_ready_i = rdy;
      if (rst) begin
         exp_q.delete(); mcount = 0; mdrop = 0; mts = 0;
      end else begin
         if (rdy && mcount > 0) mcount--;
         space = DEPTH - mcount;
         if (en && rfwe && ra != 0) begin
            if (space > 0) begin
               exp_q.push_back('{2'b01, pc, {27'd0, ra}, rd, TS_W'(mts)}); mcount++; space--;
            end else if (mdrop < 65535) mdrop++;
         end
         if (en && dmwe) begin
            if (space > 0) begin
               exp_q.push_back('{2'b10, pc, da, dd, TS_W'(mts)}); mcount++; space--;
            end else if (mdrop < 65535) mdrop++;
         end
         if (en) mts = (mts + 1) % (1 << TS_W);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input bit rdy, input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, rdy, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && mcount > 0; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("drained", mcount, 0);
   endtask

   initial begin
      @(posedge clk); #1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("rst_kind", trace_kind_o, 0);
      chk("rst_pc",   trace_pc_o, 0);
      chk("rst_addr", trace_addr_o, 0);
      chk("rst_data", trace_data_o, 0);
      chk("rst_ts",   trace_ts_o, 0);

      idle(0, 3);
      step(1, 1, 5, 32'h1234, 0, 0, 0, 32'h0C, 0, 0);
      chk("first_valid", trace_valid_o, 1);
      chk("first_kind",  trace_kind_o, 2'b01);
      chk("first_addr",  trace_addr_o, 5);
      chk("first_data",  trace_data_o, 32'h1234);
      chk("first_pc",    trace_pc_o, 32'h0C);
      chk("first_ts",    trace_ts_o, 3);
      step(1, 1, 0, 32'hDEAD, 0, 0, 0, 32'h10, 0, 0);   // R0 write, ignored
      drain();

      step(1, 1, 8, 7, 1, 32'h10, 9, 32'h20, 1, 0);
      chk("pair_count", count_o, 2);
      drain();

      for (int i = 0; i < 19; i++) step(1, 1, 5'(i % 31 + 1), 32'(i), 0, 0, 0, 32'(4 * i), 0, 0);
      chk("full_after", full_o, 1);
      chk("drop3", drop_cnt_o, 3);
      step(1, 1, 3, 32'hAA, 0, 0, 0, 32'h100, 1, 0);
      chk("swap_count", count_o, 16);
      step(1, 1, 4, 32'hBB, 1, 32'h40, 32'hCC, 32'h104, 1, 0);
      chk("swap2_drop", drop_cnt_o, 4);
      drain();

      for (int i = 0; i < 7; i++) step(1, 1, 5'(i + 1), 32'(i), 0, 0, 0, 32'(i), 0, 0);
      step(1, 1, 9, 32'h55, 0, 0, 0, 32'h200, 0, 1);
      chk("post_rst_empty", empty_o, 1);
      step(1, 1, 6, 32'h66, 0, 0, 0, 32'h204, 0, 0);
      chk("post_rst_ts", trace_ts_o, 0);
      drain();

      for (int i = 0; i < 3000; i++) begin
         logic [4:0] ra;
         ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         step($urandom_range(0, 5) != 0, $urandom_range(0, 1), ra, $urandom,
              $urandom_range(0, 2) == 0, $urandom, $urandom, $urandom,
              $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
      end
      drain();
      chk("queue_empty_end", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
